// File: rtl/filtro_distancia_hcsr04.sv
// Moving-average filter for HC-SR04 BCD distances, with proximity flag and timeout fault.
// Optional release hysteresis on perto: define FILTRO_HISTERESE_EN.
module filtro_distancia_hcsr04 #(
  parameter int LOG2_AMOSTRAS = 2,
  parameter int LIMIAR_PERTO  = 20,
  parameter int MAX_TIMEOUTS  = 3,
  parameter int HISTERESE     = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        limpa,
  input  logic        medida_pronto,
  input  logic [11:0] distancia,
  input  logic        timeout,
  output logic [9:0]  media,
  output logic        media_valida,
  output logic        perto,
  output logic        erro_sensor,
  output logic        pronto
);

  localparam int JANELA = 1 << LOG2_AMOSTRAS;
  localparam int SW     = 10 + LOG2_AMOSTRAS;
  localparam int CW     = LOG2_AMOSTRAS + 1;
  localparam int TW     = $clog2(MAX_TIMEOUTS + 1);
`ifdef FILTRO_HISTERESE_EN
  localparam int HIST_EF = HISTERESE;
`else
  // A zero release margin collapses the hold band into the plain comparison.
  localparam int HIST_EF = HISTERESE * 0;
`endif
  localparam logic [10:0]   LIM_SET = 11'(LIMIAR_PERTO);
  localparam logic [10:0]   LIM_REL = 11'(LIMIAR_PERTO + HIST_EF);
  localparam logic [CW-1:0] CHEIO   = CW'(JANELA);
  localparam logic [TW-1:0] TO_MAX  = TW'(MAX_TIMEOUTS);

  typedef enum logic [1:0] {ESPERA, CONVERTE, ATUALIZA, SAIDA} estado_t;

  estado_t                    state_q, state_d;
  logic [11:0]                dist_q, dist_d;
  logic [9:0]                 acc_q, acc_d;
  logic [1:0]                 idx_q, idx_d;
  logic                       inval_q, inval_d;
  logic [SW-1:0]              soma_q, soma_d;
  logic [LOG2_AMOSTRAS-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [TW-1:0]              to_q, to_d;
  logic                       erro_q, erro_d;
  logic [9:0]                 media_q, media_d;
  logic                       valida_q, valida_d;
  logic                       perto_q, perto_d;
  logic                       pronto_q, pronto_d;
  logic                       grava;
  logic [9:0]                 amostras_q [JANELA];

  logic [3:0]    digito;
  logic [SW-1:0] soma_new;
  logic [CW-1:0] cnt_new;
  logic [9:0]    media_new;
  logic          perto_new;

  always_comb begin
    case (idx_q)
      2'd2:    digito = dist_q[11:8];
      2'd1:    digito = dist_q[7:4];
      default: digito = dist_q[3:0];
    endcase
    soma_new  = soma_q - SW'(amostras_q[ptr_q]) + SW'(acc_q);
    cnt_new   = (cnt_q == CHEIO) ? cnt_q : cnt_q + 1'b1;
    media_new = 10'(soma_new >> LOG2_AMOSTRAS);
    if ({1'b0, media_new} < LIM_SET)       perto_new = 1'b1;
    else if ({1'b0, media_new} >= LIM_REL) perto_new = 1'b0;
    else                                   perto_new = perto_q;
  end

  always_comb begin
    state_d  = state_q;
    dist_d   = dist_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    inval_d  = inval_q;
    soma_d   = soma_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    to_d     = to_q;
    erro_d   = erro_q;
    media_d  = media_q;
    valida_d = valida_q;
    perto_d  = perto_q;
    pronto_d = 1'b0;
    grava    = 1'b0;

    if (timeout && (to_q != TO_MAX)) to_d = to_q + 1'b1;
    if (to_d == TO_MAX) erro_d = 1'b1;

    case (state_q)
      ESPERA: begin
        if (medida_pronto) begin
          dist_d  = distancia;
          acc_d   = '0;
          idx_d   = 2'd2;
          inval_d = 1'b0;
          state_d = CONVERTE;
        end
      end
      CONVERTE: begin
        acc_d = acc_q * 10'd10 + {6'd0, digito};
        if (digito > 4'd9) inval_d = 1'b1;
        idx_d = idx_q - 2'd1;
        if (idx_q == 2'd0) state_d = ATUALIZA;
      end
      ATUALIZA: begin
        if (inval_q) begin
          state_d = ESPERA;
        end else begin
          // Outputs are registered here so they appear together with pronto in SAIDA.
          state_d  = SAIDA;
          grava    = 1'b1;
          soma_d   = soma_new;
          ptr_d    = ptr_q + 1'b1;
          cnt_d    = cnt_new;
          to_d     = '0;
          erro_d   = 1'b0;
          pronto_d = 1'b1;
          if (cnt_new == CHEIO) begin
            media_d  = media_new;
            valida_d = 1'b1;
            perto_d  = perto_new;
          end
        end
      end
      SAIDA:   state_d = ESPERA;
      default: state_d = ESPERA;
    endcase

    if (limpa) begin
      state_d  = ESPERA;
      dist_d   = '0;
      acc_d    = '0;
      idx_d    = '0;
      inval_d  = 1'b0;
      soma_d   = '0;
      ptr_d    = '0;
      cnt_d    = '0;
      to_d     = '0;
      erro_d   = 1'b0;
      media_d  = '0;
      valida_d = 1'b0;
      perto_d  = 1'b0;
      pronto_d = 1'b0;
      grava    = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ESPERA;
      dist_q   <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      inval_q  <= 1'b0;
      soma_q   <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      to_q     <= '0;
      erro_q   <= 1'b0;
      media_q  <= '0;
      valida_q <= 1'b0;
      perto_q  <= 1'b0;
      pronto_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dist_q   <= dist_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      inval_q  <= inval_d;
      soma_q   <= soma_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      to_q     <= to_d;
      erro_q   <= erro_d;
      media_q  <= media_d;
      valida_q <= valida_d;
      perto_q  <= perto_d;
      pronto_q <= pronto_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < JANELA; i++) amostras_q[i] <= '0;
    end else if (limpa) begin
      for (int i = 0; i < JANELA; i++) amostras_q[i] <= '0;
    end else if (grava) begin
      amostras_q[ptr_q] <= acc_q;
    end
  end

  assign media        = media_q;
  assign media_valida = valida_q;
  assign perto        = perto_q;
  assign erro_sensor  = erro_q;
  assign pronto       = pronto_q;

endmodule
